arbitrated_mux_bus: RTL and testbench

ARBITRATED_MUX_BUS -- requirements
Module: arbitrated_mux_bus

---
 rtl/mux_bus_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/arbitrated_mux_bus.sv | 84 ++++++++
 tb/tb_arbitrated_mux_bus.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_bus_pkg.sv
// Shared constants and helpers for the arbitrated mux bus.
package mux_bus_pkg;

    // Grant selection modes
    localparam int unsigned MODE_SELECT = 0;
    localparam int unsigned MODE_RR     = 1;

    // Number of bits needed to index 'value' items (value >= 1)
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping around; the pointer moves past the grantee only on 'advance'.
module rr_arbiter
    import mux_bus_pkg::*;
#(
    parameter int unsigned NrOfInputs = 4,
    parameter int unsigned SelBits    = clog2(NrOfInputs)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NrOfInputs-1:0] req,
    input  logic                  advance,
    output logic [NrOfInputs-1:0] grant,
    output logic [SelBits-1:0]    grant_idx
);

    logic [SelBits-1:0] ptr_q, ptr_d;
    logic               found;
    int unsigned        idx;
    logic [SelBits-1:0] idx_sel;

    // Search upward from the pointer for the first active request
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_sel   = '0;
        for (int unsigned k = 0; k < NrOfInputs; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NrOfInputs) begin
                idx = idx - NrOfInputs;
            end
            idx_sel = SelBits'(idx);
            if (!found && req[idx_sel]) begin
                found          = 1'b1;
                grant[idx_sel] = 1'b1;
                grant_idx      = idx_sel;
            end
        end
    end

    // Pointer moves to the channel after the one that just transferred
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (grant_idx == SelBits'(NrOfInputs - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/arbitrated_mux_bus.sv
// N-to-1 multiplexer with valid/ready handshakes on every channel and a
// single registered output stage; grant is by explicit select or round robin.
module arbitrated_mux_bus
    import mux_bus_pkg::*;
#(
    parameter  int unsigned NrOfBits   = 32,
    parameter  int unsigned NrOfInputs = 4,
    parameter  int unsigned Mode       = MODE_RR,
    localparam int unsigned SelBits    = clog2(NrOfInputs)
) (
    input  logic                           Clock,
    input  logic                           nReset,
    input  logic                           Enable,
    input  logic [NrOfInputs*NrOfBits-1:0] MuxIn,
    input  logic [NrOfInputs-1:0]          InValid,
    output logic [NrOfInputs-1:0]          InReady,
    input  logic [SelBits-1:0]             Sel,
    output logic [NrOfBits-1:0]            MuxOut,
    output logic                           OutValid,
    input  logic                           OutReady,
    output logic [SelBits-1:0]             OutSrc
);

    logic                  load_ok;
    logic                  accept_en;
    logic                  xfer;
    logic [NrOfInputs-1:0] grant;
    logic [SelBits-1:0]    grant_idx;

    // Output stage may load when empty or being drained this cycle
    assign load_ok   = !OutValid || OutReady;
    // Reset term keeps InReady low while held in reset
    assign accept_en = load_ok && Enable && nReset;
    assign xfer      = |(InValid & grant);
    assign InReady   = grant;

    if (Mode == MODE_RR) begin : g_rr
        logic [NrOfInputs-1:0] rr_grant;
        logic                  unused_sel;

        assign unused_sel = ^Sel;

        rr_arbiter #(
            .NrOfInputs(NrOfInputs),
            .SelBits   (SelBits)
        ) u_arb (
            .clk      (Clock),
            .rst_n    (nReset),
            .req      (InValid),
            .advance  (xfer),
            .grant    (rr_grant),
            .grant_idx(grant_idx)
        );

        // Arbiter only proposes; the output stage decides whether to accept
        assign grant = accept_en ? rr_grant : '0;
    end else begin : g_sel
        // Explicit select; out-of-range selects grant nothing
        always_comb begin
            grant = '0;
            if (accept_en && (32'(Sel) < NrOfInputs)) begin
                grant[Sel] = 1'b1;
            end
        end

        assign grant_idx = Sel;
    end

    // Output register: load on input transfer, otherwise clear valid on drain
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            OutValid <= 1'b0;
            MuxOut   <= '0;
            OutSrc   <= '0;
        end else if (xfer) begin
            OutValid <= 1'b1;
            MuxOut   <= MuxIn[grant_idx*NrOfBits +: NrOfBits];
            OutSrc   <= grant_idx;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arbitrated_mux_bus.sv
// Directed bench for arbitrated_mux_bus: one select-mode and one round-robin
// instance share stimulus; a reference model feeds per-instance scoreboards.
module tb_arbitrated_mux_bus;

    logic         clk = 1'b0;
    logic         nreset;
    logic         enable;
    logic         out_ready;
    logic [127:0] mux_in;
    logic [3:0]   in_valid;
    logic [1:0]   sel;

    logic [3:0]   rdy0, rdy1;
    logic [31:0]  mux0, mux1;
    logic         ov0, ov1;
    logic [1:0]   src0, src1;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit          mv0, mv1;
    int          p;
    logic [33:0] q0[$];
    logic [33:0] q1[$];
    logic [33:0] last0, last1;

    always #5 clk = ~clk;

    arbitrated_mux_bus #(
        .NrOfBits  (32),
        .NrOfInputs(4),
        .Mode      (0)
    ) dut_sel (
        .Clock   (clk),
        .nReset  (nreset),
        .Enable  (enable),
        .MuxIn   (mux_in),
        .InValid (in_valid),
        .InReady (rdy0),
        .Sel     (sel),
        .MuxOut  (mux0),
        .OutValid(ov0),
        .OutReady(out_ready),
        .OutSrc  (src0)
    );

    arbitrated_mux_bus #(
        .NrOfBits  (32),
        .NrOfInputs(4),
        .Mode      (1)
    ) dut_rr (
        .Clock   (clk),
        .nReset  (nreset),
        .Enable  (enable),
        .MuxIn   (mux_in),
        .InValid (in_valid),
        .InReady (rdy1),
        .Sel     (sel),
        .MuxOut  (mux1),
        .OutValid(ov1),
        .OutReady(out_ready),
        .OutSrc  (src1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [15:0] seed);
        for (int i = 0; i < 4; i++) begin
            mux_in[i*32 +: 32] = {seed, 16'(i)};
        end
    endtask

    // Entered just after a rising edge; checks at the falling edge, then
    // advances the model across the next rising edge.
    task automatic cycle(input string tag);
        logic [3:0]  r0, r1;
        logic [33:0] e;
        int          g;
        @(negedge clk);
        r0 = '0;
        if (enable && (!mv0 || out_ready)) r0[sel] = 1'b1;
        r1 = '0;
        g  = -1;
        if (enable && (!mv1 || out_ready)) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && in_valid[(p + k) % 4]) g = (p + k) % 4;
            end
        end
        if (g >= 0) r1[g] = 1'b1;
        check({tag, " sel InReady"}, 64'(rdy0), 64'(r0));
        check({tag, " rr InReady"}, 64'(rdy1), 64'(r1));

        check({tag, " sel OutValid"}, 64'(ov0), 64'(mv0));
        e = (mv0 && q0.size() > 0) ? q0[0] : last0;
        check({tag, " sel MuxOut"}, 64'(mux0), 64'(e[31:0]));
        check({tag, " sel OutSrc"}, 64'(src0), 64'(e[33:32]));
        if (mv0 && out_ready && q0.size() > 0) last0 = q0.pop_front();

        check({tag, " rr OutValid"}, 64'(ov1), 64'(mv1));
        e = (mv1 && q1.size() > 0) ? q1[0] : last1;
        check({tag, " rr MuxOut"}, 64'(mux1), 64'(e[31:0]));
        check({tag, " rr OutSrc"}, 64'(src1), 64'(e[33:32]));
        if (mv1 && out_ready && q1.size() > 0) last1 = q1.pop_front();

        if ((r0 & in_valid) != 4'b0000) begin
            q0.push_back({sel, mux_in[sel*32 +: 32]});
            mv0 = 1'b1;
        end else if (out_ready) begin
            mv0 = 1'b0;
        end
        if (g >= 0) begin
            q1.push_back({2'(g), mux_in[g*32 +: 32]});
            p   = (g + 1) % 4;
            mv1 = 1'b1;
        end else if (out_ready) begin
            mv1 = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear at once
    task automatic do_reset(input string tag);
        #2 nreset = 1'b0;
        #1;
        check({tag, " sel OutValid"}, 64'(ov0), 64'd0);
        check({tag, " sel MuxOut"}, 64'(mux0), 64'd0);
        check({tag, " sel OutSrc"}, 64'(src0), 64'd0);
        check({tag, " sel InReady"}, 64'(rdy0), 64'd0);
        check({tag, " rr OutValid"}, 64'(ov1), 64'd0);
        check({tag, " rr MuxOut"}, 64'(mux1), 64'd0);
        check({tag, " rr OutSrc"}, 64'(src1), 64'd0);
        check({tag, " rr InReady"}, 64'(rdy1), 64'd0);
        mv0   = 1'b0;
        mv1   = 1'b0;
        p     = 0;
        last0 = '0;
        last1 = '0;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1 nreset = 1'b1;
    endtask

    initial begin
        nreset    = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b0000;
        sel       = 2'd0;
        set_data(16'h0000);
        do_reset("por");

        // Explicit select of channel 2
        sel      = 2'd2;
        in_valid = 4'b0100;
        set_data(16'hA5A5);
        cycle("m0 load");
        check("m0 direct OutValid", 64'(ov0), 64'd1);
        check("m0 direct MuxOut", 64'(mux0), 64'h0000_0000_A5A5_0002);
        check("m0 direct OutSrc", 64'(src0), 64'd2);
        in_valid = 4'b0000;
        cycle("m0 drain");
        cycle("m0 idle hold");

        // Selected channel not valid: ready but no transfer
        sel      = 2'd1;
        in_valid = 4'b0001;
        set_data(16'h0B0B);
        cycle("m0 sel idle");
        sel       = 2'd0;
        out_ready = 1'b0;
        set_data(16'h0C0C);
        cycle("m0 load no drain");
        set_data(16'h0D0D);
        cycle("m0 stall");
        out_ready = 1'b1;
        in_valid  = 4'b0000;
        cycle("m0 release");
        cycle("m0 empty");

        // Round robin over all-valid inputs from pointer 0
        do_reset("rst2");
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            set_data(16'h1000 + 16'(i));
            cycle("rr all valid");
            check("rr sequence OutSrc", 64'(src1), 64'(i % 4));
            check("rr sequence OutValid", 64'(ov1), 64'd1);
        end

        // Move pointer to 1, then sparse requests wrap 3 -> 0 -> 3
        in_valid = 4'b0001;
        set_data(16'h2000);
        cycle("rr ptr to 1");
        in_valid = 4'b1001;
        set_data(16'h2001);
        cycle("rr wrap a");
        check("rr wrap first", 64'(src1), 64'd3);
        set_data(16'h2002);
        cycle("rr wrap b");
        check("rr wrap second", 64'(src1), 64'd0);
        set_data(16'h2003);
        cycle("rr wrap c");
        check("rr wrap third", 64'(src1), 64'd3);

        // Backpressure: everything must hold, nothing consumed
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            set_data(16'h3000 + 16'(i));
            cycle("stall");
        end

        // Disable while a word is held: it drains, nothing new loads
        enable    = 1'b0;
        out_ready = 1'b1;
        set_data(16'h4000);
        cycle("disable drain");
        cycle("disable idle a");
        cycle("disable idle b");
        enable = 1'b1;
        set_data(16'h4001);
        cycle("enable again");

        // Reset mid-stream, then first grant goes to channel 0
        set_data(16'h5000);
        cycle("pre reset");
        do_reset("mid reset");
        set_data(16'h5001);
        cycle("post reset");
        check("post reset OutSrc", 64'(src1), 64'd0);
        check("post reset OutValid", 64'(ov1), 64'd1);
        in_valid = 4'b0000;
        cycle("final drain");
        cycle("final idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
